eight_to_three_rr_encoder: RTL and testbench
============================================

# eight_to_three_rr_encoder

Registered 8-to-3 round-robin request encoder for the register-file control path. It takes up to eight simultaneous request lines and produces one granted 3-bit index per accepted transfer. A rotating priority pointer guarantees fairness. The granted index and its one-hot form are held stable under a valid/ready handshake until the consumer accepts them.

## Interface
Parameters:
- None. Widths are fixed at 8 requests and a 3-bit index; the constants live in the shared package.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  permits loading a new grant; 0 = no new grant issued
- req  input  8  request lines; bit k = requester k wants a grant; multi-hot allowed
- out_ready  input  1  consumer accepts the current grant this cycle
- out_valid  output  1  grant index is valid
- out_idx  output  3  granted requester index
- out_onehot  output  8  one-hot of out_idx when out_valid=1, else 8'h00
- out_accept  output  1  combinational: out_valid & out_ready; requester out_idx may drop req

## Operation
- State: ptr[2:0] (highest-priority index next search), out_valid, out_idx.
- Load condition: load = !out_valid | out_ready.
- On load with enable=1 and req≠0:
  - search req cyclically from ptr upward: ptr, ptr+1, …, 7, 0, …, ptr-1;
  - the first set bit k wins;
  - out_idx←k, out_valid←1, ptr←(k+1) mod 8.
- On load with enable=0 or req=0: out_valid←0; out_idx and ptr unchanged.
- No load (out_valid=1, out_ready=0): out_idx, out_valid and ptr are held; req changes are ignored.
- ptr advances only when a grant is loaded, never on idle cycles.
- out_onehot is derived from registered out_idx/out_valid and is glitch-free relative to clk.
- A requester whose req drops while its grant is pending still has that grant completed; the encoder does not revoke grants.

## Timing
- Reset values: out_valid=0, out_idx=3'd0, out_onehot=8'h00, ptr=3'd0; out_accept=0 follows from out_valid.
- Reset overrides enable, req and out_ready on the same edge. Reset mid-stall discards the pending grant.
- Latency:
  - req sampled at edge N yields out_valid/out_idx visible after edge N (1 cycle);
  - accept at edge N with req still pending yields the next grant after edge N, so throughput is 1 grant/cycle with out_ready held high.
- Simultaneous accept and load occur on the same edge: the old grant is retired and the new one loaded.
- Wrap-around: grant k=7 sets ptr=0.
- A single continuous requester is re-granted every cycle.

## Structure
- Package eight_to_three_pkg: N_REQ=8, IDX_W=3, and typedef logic [IDX_W-1:0] idx_t.
- Sub-module rr_priority_encoder_8to3 (combinational):
  - inputs req[7:0] and ptr[2:0];
  - outputs any (1) and idx (3);
  - implemented as rotate-right by ptr, fixed LSB-first priority encode, then add ptr mod 8.
- The top level holds only the ptr/out registers, the load logic and the one-hot decode.

## Test plan
- Reset: assert reset 2 cycles with req=8'hFF, enable=1 → out_valid=0, out_idx=0, out_onehot=8'h00 throughout; after release, first grant idx=0.
- Single request: req=8'h04, enable=1, out_ready=1 → after 1 edge out_valid=1, out_idx=2, out_onehot=8'h04; next grant idx=2 again (ptr=3 wraps the search to 2).
- Fairness: req=8'hFF, out_ready=1 for 10 cycles → out_idx sequence 0,1,2,3,4,5,6,7,0,1.
- Stall: req=8'h81 with out_ready=0 for 3 cycles → out_idx=0 held, ptr unchanged; change req to 8'h02 during the stall → no change; then out_ready=1 → accept pulses, next out_idx=1.
- Wrap and idle:
  - after grant idx=7, req=8'h81 → next idx=0;
  - req=8'h00 with out_ready=1 → out_valid drops to 0 and ptr holds;
  - enable=0 with req=8'hFF → out_valid stays 0.
- Reset mid-operation: assert reset while out_valid=1, out_ready=0, out_idx=5 → next edge all outputs 0 and ptr=0; after release with req=8'h60, grant idx=5.

Source files
------------

// File: rtl/eight_to_three_rr_encoder_pkg.sv
// Shared constants and types for the 8-to-3 round-robin request encoder.
package eight_to_three_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/eight_to_three_rr_encoder_if.sv
// Request/grant bundle between the requesters, the encoder and the grant consumer.
interface eight_to_three_rr_encoder_if;
    import eight_to_three_pkg::*;

    logic             enable;
    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic             out_valid;
    idx_t             out_idx;
    logic [N_REQ-1:0] out_onehot;
    logic             out_accept;

    // Encoder side: samples requests and the consumer's ready, presents the grant.
    modport slave (
        input  enable,
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output out_accept
    );

    // Environment side: drives requests and ready, observes the grant.
    modport master (
        output enable,
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  out_accept
    );

endinterface

// File: rtl/eight_to_three_rr_encoder_rr_priority_encoder_8to3.sv
// Combinational round-robin search: first set request at or after ptr, wrapping at 8.
module rr_priority_encoder_8to3
    import eight_to_three_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  idx_t             ptr_i,
    output logic             any_o,
    output idx_t             idx_o
);

    logic [N_REQ-1:0] rot;
    idx_t             off;

    // Rotate right by ptr so the highest-priority requester lands on bit 0;
    // the 3-bit index sum wraps modulo 8 on its own.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req_i[idx_t'(i) + ptr_i];
        end
    end

    // Fixed LSB-first priority encode of the rotated vector.
    always_comb begin
        // NOTE: default every combinational output before any conditional so no latch is inferred.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = idx_t'(i);
            end
        end
    end

    assign any_o = |req_i;
    assign idx_o = off + ptr_i;

endmodule

// File: rtl/eight_to_three_rr_encoder.sv
// Registered 8-to-3 round-robin request encoder with a valid/ready grant output.
module eight_to_three_rr_encoder
    import eight_to_three_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    eight_to_three_rr_encoder_if.slave  bus
);

    logic valid_q, valid_d;
    idx_t idx_q,   idx_d;
    idx_t ptr_q,   ptr_d;

    logic load;
    logic hit_any;
    idx_t hit_idx;

    rr_priority_encoder_8to3 u_search (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (hit_any),
        .idx_o (hit_idx)
    );

    // A new grant may be loaded when the output slot is empty or being retired this cycle.
    assign load = !valid_q || bus.out_ready;

    // Next-state: load a grant, go idle, or hold the pending grant untouched.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (bus.enable && hit_any) begin
                valid_d = 1'b1;
                idx_d   = hit_idx;
                ptr_d   = hit_idx + idx_t'(1);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any pending grant and restarts the pointer at 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = valid_q ? (N_REQ'(1) << idx_q) : '0;
    assign bus.out_accept = valid_q && bus.out_ready;

endmodule

// File: tb/tb_eight_to_three_rr_encoder.sv
// Self-checking bench: cycle model of the round-robin rules plus directed literal checks.
module tb_eight_to_three_rr_encoder;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    eight_to_three_rr_encoder_if bus_if ();

    eight_to_three_rr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Search requests cyclically starting at p; returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (int'(p) + i) % 8;
            if (r[k]) return {1'b1, 3'(k)};
        end
        return 4'b0000;
    endfunction

    // Behavioural model state.
    logic       started;
    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    logic [3:0] m_pick;

    assign m_pick = rr_pick(bus_if.req, m_ptr);

    initial started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 3'd0;
            m_ptr   <= 3'd0;
        end else if (!m_valid || bus_if.out_ready) begin
            if (bus_if.enable && m_pick[3]) begin
                m_valid <= 1'b1;
                m_idx   <= m_pick[2:0];
                m_ptr   <= 3'((int'(m_pick[2:0]) + 1) % 8);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (started) begin
            check("model_valid",  bus_if.out_valid,  m_valid);
            check("model_idx",    bus_if.out_idx,    m_idx);
            check("model_onehot", bus_if.out_onehot, m_valid ? (8'h01 << m_idx) : 8'h00);
            check("model_accept", bus_if.out_accept, m_valid && bus_if.out_ready);
            check("model_ptr",    dut.ptr_q,         m_ptr);
        end
    end

    task automatic step(input logic rst, input logic en, input logic [7:0] r, input logic rdy);
        reset            = rst;
        bus_if.enable    = en;
        bus_if.req       = r;
        bus_if.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset            = 1'b1;
        bus_if.enable    = 1'b1;
        bus_if.req       = 8'hFF;
        bus_if.out_ready = 1'b0;

        // Reset held two cycles with everything requesting.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 8'hFF, 1'b0);
            check("rst_valid",  bus_if.out_valid,  1'b0);
            check("rst_idx",    bus_if.out_idx,    3'd0);
            check("rst_onehot", bus_if.out_onehot, 8'h00);
        end
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        check("first_grant", bus_if.out_idx, 3'd0);

        // Single requester re-granted each cycle.
        step(1'b0, 1'b1, 8'h04, 1'b1);
        check("single_valid",  bus_if.out_valid,  1'b1);
        check("single_idx",    bus_if.out_idx,    3'd2);
        check("single_onehot", bus_if.out_onehot, 8'h04);
        step(1'b0, 1'b1, 8'h04, 1'b1);
        check("single_again", bus_if.out_idx, 3'd2);

        // Fairness from a fresh pointer.
        step(1'b1, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'hFF, 1'b1);
            check("fair_idx", bus_if.out_idx, 32'(i % 8));
        end

        // Stall: grant 0 held, request changes ignored, then accepted.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h81, 1'b0);
        check("stall_load", bus_if.out_idx, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, (i == 2) ? 8'h02 : 8'h81, 1'b0);
            check("stall_idx",    bus_if.out_idx,    3'd0);
            check("stall_accept", bus_if.out_accept, 1'b0);
        end
        bus_if.req       = 8'h02;
        bus_if.out_ready = 1'b1;
        #1;
        check("stall_accept_pulse", bus_if.out_accept, 1'b1);
        @(posedge clk);
        #1;
        check("stall_next", bus_if.out_idx, 3'd1);

        // Wrap-around past index 7.
        step(1'b0, 1'b1, 8'h80, 1'b1);
        check("wrap_7", bus_if.out_idx, 3'd7);
        step(1'b0, 1'b1, 8'h81, 1'b1);
        check("wrap_0", bus_if.out_idx, 3'd0);

        // Idle: no requests, then disabled.
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("idle_valid", bus_if.out_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'hFF, 1'b1);
            check("disabled_valid", bus_if.out_valid, 1'b0);
        end

        // Reset while a grant for index 5 is stalled.
        step(1'b0, 1'b1, 8'h20, 1'b0);
        step(1'b0, 1'b1, 8'h20, 1'b0);
        check("pre_rst_idx", bus_if.out_idx, 3'd5);
        step(1'b1, 1'b1, 8'h20, 1'b0);
        check("midrst_valid",  bus_if.out_valid,  1'b0);
        check("midrst_idx",    bus_if.out_idx,    3'd0);
        check("midrst_onehot", bus_if.out_onehot, 8'h00);
        step(1'b0, 1'b1, 8'h60, 1'b1);
        check("post_rst_idx", bus_if.out_idx, 3'd5);
        step(1'b0, 1'b1, 8'h60, 1'b1);
        check("post_rst_next", bus_if.out_idx, 3'd6);

        step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
